// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states, access owner encoding and
// the counter width helper.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter (AVR stalling port + DMA req/ack) onto one asynchronous
// SRAM, with registered strobes held for ACCESS_CYCLES and a recovery cycle.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 17,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_d_out,
    input  logic              cpu_cs,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_d_in,
    output logic              cpu_wait,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_we,
    input  logic              dma_req,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_dq_o,
    output logic              mem_dq_oe,
    input  logic [DATA_W-1:0] mem_dq_i,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
);

    localparam int               CNT_W    = clog2(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t           state;
    owner_t           owner;
    owner_t           last_grant;
    logic [CNT_W-1:0] cnt;
    logic             wr_op;

    logic cpu_vld;
    logic grant_dma;
    logic sel_wr;

    assign cpu_vld = cpu_cs & (cpu_oe | cpu_we);

    // Round robin: on a tie the requester that did not win last time goes.
    assign grant_dma = dma_req & (~cpu_vld | (last_grant == OWN_CPU));
    assign sel_wr    = grant_dma ? dma_we : cpu_we;

    // Released only in the CPU's own recovery cycle, so the core stalls
    // from the very first cycle it raises cs.
    assign cpu_wait = cpu_vld & ~((state == RECOVER) & (owner == OWN_CPU));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_grant <= OWN_DMA;
            cnt        <= '0;
            wr_op      <= 1'b0;
            mem_a      <= '0;
            mem_dq_o   <= '0;
            mem_dq_oe  <= 1'b0;
            mem_ce_n   <= 1'b1;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            cpu_d_in   <= '0;
            dma_rdata  <= '0;
            dma_ack    <= 1'b0;
        end else begin
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_vld | dma_req) begin
                        state      <= ACCESS;
                        cnt        <= CNT_LOAD;
                        owner      <= grant_dma ? OWN_DMA : OWN_CPU;
                        last_grant <= grant_dma ? OWN_DMA : OWN_CPU;
                        wr_op      <= sel_wr;
                        mem_a      <= grant_dma ? dma_addr : cpu_a;
                        mem_dq_o   <= grant_dma ? dma_wdata : cpu_d_out;
                        mem_ce_n   <= 1'b0;
                        mem_oe_n   <= sel_wr;
                        mem_we_n   <= ~sel_wr;
                        mem_dq_oe  <= sel_wr;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state     <= RECOVER;
                        mem_ce_n  <= 1'b1;
                        mem_oe_n  <= 1'b1;
                        mem_we_n  <= 1'b1;
                        mem_dq_oe <= 1'b0;
                        dma_ack   <= (owner == OWN_DMA);
                        if (!wr_op) begin
                            if (owner == OWN_DMA) dma_rdata <= mem_dq_i;
                            else                  cpu_d_in  <= mem_dq_i;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // mem_a / mem_dq_o are left untouched here for hold time.
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with ACCESS_CYCLES=2 and a
// second with ACCESS_CYCLES=1, each against a simple read-back SRAM model.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] cpu_a = '0;
    logic [7:0]  cpu_d_out = '0;
    logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_d_in;
    logic        cpu_wait;
    logic [16:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_we = 1'b0, dma_req = 1'b0;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [16:0] mem_a;
    logic [7:0]  mem_dq_o, mem_dq_i;
    logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n;

    logic [16:0] b_dma_addr = '0;
    logic        b_dma_req = 1'b0;
    logic        b_dma_ack;
    logic [7:0]  b_dma_rdata, b_cpu_d_in, b_mem_dq_o, b_mem_dq_i;
    logic        b_cpu_wait, b_mem_dq_oe, b_mem_ce_n, b_mem_oe_n, b_mem_we_n;
    logic [16:0] b_mem_a;

    // SRAM model: read data is the low address byte XOR 0xD3.
    assign mem_dq_i   = mem_oe_n   ? 8'h00 : (mem_a[7:0] ^ 8'hD3);
    assign b_mem_dq_i = b_mem_oe_n ? 8'h00 : (b_mem_a[7:0] ^ 8'hD3);

    sram_arbiter #(.ADDR_W(17), .DATA_W(8), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_a(cpu_a), .cpu_d_out(cpu_d_out), .cpu_cs(cpu_cs), .cpu_oe(cpu_oe),
        .cpu_we(cpu_we), .cpu_d_in(cpu_d_in), .cpu_wait(cpu_wait),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_req(dma_req), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_a(mem_a), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
        .mem_dq_i(mem_dq_i), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n),
        .mem_we_n(mem_we_n)
    );

    sram_arbiter #(.ADDR_W(17), .DATA_W(8), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .nrst(nrst),
        .cpu_a(17'h0), .cpu_d_out(8'h00), .cpu_cs(1'b0), .cpu_oe(1'b0),
        .cpu_we(1'b0), .cpu_d_in(b_cpu_d_in), .cpu_wait(b_cpu_wait),
        .dma_addr(b_dma_addr), .dma_wdata(8'h00), .dma_we(1'b0),
        .dma_req(b_dma_req), .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
        .mem_a(b_mem_a), .mem_dq_o(b_mem_dq_o), .mem_dq_oe(b_mem_dq_oe),
        .mem_dq_i(b_mem_dq_i), .mem_ce_n(b_mem_ce_n), .mem_oe_n(b_mem_oe_n),
        .mem_we_n(b_mem_we_n)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic nc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ce_n",  32'(mem_ce_n), 32'h1);
        chk("rst_oe_n",  32'(mem_oe_n), 32'h1);
        chk("rst_we_n",  32'(mem_we_n), 32'h1);
        chk("rst_dq_oe", 32'(mem_dq_oe), 32'h0);
        chk("rst_a",     32'(mem_a), 32'h0);
        chk("rst_ack",   32'(dma_ack), 32'h0);
        chk("rst_cpu_d", 32'(cpu_d_in), 32'h0);
        chk("rst_dma_d", 32'(dma_rdata), 32'h0);
        nc(1);
        nrst = 1'b1;
        nc(2);

        // DMA write 0x5A -> 0x00123; cycle 0 is this negedge
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'h00123; dma_wdata = 8'h5A;
        #1 chk("dw_c0_ce_n", 32'(mem_ce_n), 32'h1);
        for (int c = 1; c <= 2; c++) begin
            nc(1);
            chk("dw_we_n",  32'(mem_we_n), 32'h0);
            chk("dw_ce_n",  32'(mem_ce_n), 32'h0);
            chk("dw_oe_n",  32'(mem_oe_n), 32'h1);
            chk("dw_a",     32'(mem_a), 32'h00123);
            chk("dw_dq_o",  32'(mem_dq_o), 32'h5A);
            chk("dw_dq_oe", 32'(mem_dq_oe), 32'h1);
            chk("dw_ack0",  32'(dma_ack), 32'h0);
        end
        nc(1);
        chk("dw_c3_ack",   32'(dma_ack), 32'h1);
        chk("dw_c3_we_n",  32'(mem_we_n), 32'h1);
        chk("dw_c3_ce_n",  32'(mem_ce_n), 32'h1);
        chk("dw_c3_dq_oe", 32'(mem_dq_oe), 32'h0);
        chk("dw_c3_a",     32'(mem_a), 32'h00123);
        chk("dw_c3_dq_o",  32'(mem_dq_o), 32'h5A);
        dma_req = 1'b0;
        nc(1);
        chk("dw_c4_ack",  32'(dma_ack), 32'h0);
        chk("dw_c4_ce_n", 32'(mem_ce_n), 32'h1);
        nc(1);

        // CPU read of 0x00010 -> 0xC3
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 17'h00010;
        #1 chk("cr_c0_wait", 32'(cpu_wait), 32'h1);
        nc(1);
        chk("cr_c1_wait", 32'(cpu_wait), 32'h1);
        chk("cr_c1_oe_n", 32'(mem_oe_n), 32'h0);
        chk("cr_c1_we_n", 32'(mem_we_n), 32'h1);
        chk("cr_c1_dqoe", 32'(mem_dq_oe), 32'h0);
        nc(1);
        chk("cr_c2_wait", 32'(cpu_wait), 32'h1);
        nc(1);
        chk("cr_c3_wait", 32'(cpu_wait), 32'h0);
        chk("cr_c3_d",    32'(cpu_d_in), 32'hC3);
        chk("cr_c3_ack",  32'(dma_ack), 32'h0);
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        nc(10);
        chk("cr_hold_d",    32'(cpu_d_in), 32'hC3);
        chk("cr_hold_wait", 32'(cpu_wait), 32'h0);

        // Tie after reset: CPU, DMA, CPU
        nrst = 1'b0; #2 nrst = 1'b1;
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 17'h00020;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h00030;
        nc(1);
        chk("rr_g1_a",    32'(mem_a), 32'h00020);
        chk("rr_g1_oe_n", 32'(mem_oe_n), 32'h0);
        nc(2);
        chk("rr_g1_wait", 32'(cpu_wait), 32'h0);
        chk("rr_g1_d",    32'(cpu_d_in), 32'hF3);
        nc(1);
        chk("rr_c4_wait", 32'(cpu_wait), 32'h1);
        nc(1);
        chk("rr_g2_a",    32'(mem_a), 32'h00030);
        nc(2);
        chk("rr_g2_ack",  32'(dma_ack), 32'h1);
        chk("rr_g2_d",    32'(dma_rdata), 32'hE3);
        nc(2);
        chk("rr_g3_a",    32'(mem_a), 32'h00020);
        chk("rr_g3_ack",  32'(dma_ack), 32'h0);
        nc(2);
        chk("rr_g3_wait", 32'(cpu_wait), 32'h0);
        cpu_cs = 1'b0; cpu_oe = 1'b0; dma_req = 1'b0;
        nc(1);
        chk("rr_end_ce_n", 32'(mem_ce_n), 32'h1);
        nc(1);

        // DMA in flight, CPU arrives at cycle 1
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'h00040; dma_wdata = 8'h11;
        nc(1);
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 17'h00050;
        #1 chk("ov_c1_wait", 32'(cpu_wait), 32'h1);
        nc(1);
        chk("ov_c2_oe_n", 32'(mem_oe_n), 32'h1);
        chk("ov_c2_a",    32'(mem_a), 32'h00040);
        nc(1);
        chk("ov_c3_ack",  32'(dma_ack), 32'h1);
        chk("ov_c3_ce_n", 32'(mem_ce_n), 32'h1);
        dma_req = 1'b0;
        nc(1);
        chk("ov_c4_ce_n", 32'(mem_ce_n), 32'h1);
        nc(1);
        chk("ov_c5_ce_n", 32'(mem_ce_n), 32'h0);
        chk("ov_c5_oe_n", 32'(mem_oe_n), 32'h0);
        chk("ov_c5_we_n", 32'(mem_we_n), 32'h1);
        chk("ov_c5_a",    32'(mem_a), 32'h00050);
        nc(2);
        chk("ov_c7_wait", 32'(cpu_wait), 32'h0);
        chk("ov_c7_d",    32'(cpu_d_in), 32'h83);
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        nc(2);

        // Reset asserted during the ACCESS of a DMA write
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'h00060; dma_wdata = 8'h22;
        nc(1);
        chk("ra_c1_we_n", 32'(mem_we_n), 32'h0);
        #1 nrst = 1'b0;
        #1;
        chk("ra_async_we_n",  32'(mem_we_n), 32'h1);
        chk("ra_async_ce_n",  32'(mem_ce_n), 32'h1);
        chk("ra_async_dq_oe", 32'(mem_dq_oe), 32'h0);
        chk("ra_async_a",     32'(mem_a), 32'h0);
        nc(1);
        chk("ra_held_ack",  32'(dma_ack), 32'h0);
        chk("ra_held_ce_n", 32'(mem_ce_n), 32'h1);
        nrst = 1'b1;
        nc(1);
        chk("ra_re_we_n", 32'(mem_we_n), 32'h0);
        chk("ra_re_a",    32'(mem_a), 32'h00060);
        chk("ra_re_dq_o", 32'(mem_dq_o), 32'h22);
        nc(1);
        chk("ra_re_c2_ack", 32'(dma_ack), 32'h0);
        nc(1);
        chk("ra_re_c3_ack", 32'(dma_ack), 32'h1);
        dma_req = 1'b0;
        nc(1);
        chk("ra_re_c4_ack", 32'(dma_ack), 32'h0);
        nc(1);

        // ACCESS_CYCLES=1: back-to-back DMA reads 0..3
        b_dma_req = 1'b1; b_dma_addr = 17'h00000;
        for (int i = 0; i < 4; i++) begin
            nc(1);
            chk("ac1_oe_n", 32'(b_mem_oe_n), 32'h0);
            chk("ac1_ce_n", 32'(b_mem_ce_n), 32'h0);
            chk("ac1_a",    32'(b_mem_a), 32'(i));
            chk("ac1_ack0", 32'(b_dma_ack), 32'h0);
            nc(1);
            chk("ac1_ack",   32'(b_dma_ack), 32'h1);
            chk("ac1_rdata", 32'(b_dma_rdata), 32'(8'(i) ^ 8'hD3));
            chk("ac1_rc_ce_n", 32'(b_mem_ce_n), 32'h1);
            if (i == 3) b_dma_req = 1'b0;
            else        b_dma_addr = 17'(i + 1);
            nc(1);
            chk("ac1_idle_ack",  32'(b_dma_ack), 32'h0);
            chk("ac1_idle_ce_n", 32'(b_mem_ce_n), 32'h1);
        end
        nc(2);
        chk("ac1_end_ce_n", 32'(b_mem_ce_n), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
